mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller. It is the initiator on the external 8-bit RAM bus, and the other end of the cache/LSU word-access interface.
- It accepts one byte, half or word read/write request at a time from the cache/MEM stage.
- It splits each request into little-endian byte transactions on the RAM bus and returns one response per request.
- Sits between the cache (upstream) and the single-ported RAM with 1-cycle read latency (downstream).

Parameters:
- ADDR_W, 17, byte-address width of the request and the RAM bus.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_sel  input  2  access size: 01 byte, 10 half, 11 word, 00 null.
- req_addr  input  ADDR_W  start byte address.
- req_wdata  input  32  write data; low N bytes are used.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  read data, zero-extended; 0 for writes.
- resp_err  output  1  misaligned access rejected (optional feature only).
- mem_a  output  ADDR_W  RAM byte address.
- mem_dout  output  8  RAM write byte.
- mem_din  input  8  RAM read byte; valid the cycle after mem_a is presented with mem_wr=0.
- mem_wr  output  1  RAM write strobe.

Behaviour:
- Clocking and reset: all state is on the rising edge of clk.
- While rst=0 (sampled at the edge), the following hold after that edge:
  - state=IDLE, req_ready=1;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - mem_a=0, mem_dout=0, mem_wr=0.
- States:
  - IDLE: wait for a request.
  - ISSUE: drive byte transactions on the RAM bus.
  - CAPTURE: final read-data capture (reads only).
  - DONE: response cycle.
- req_ready=1 only in IDLE.
- Accept: a request is accepted at the cycle T where req_valid=1 and req_ready=1. At acceptance the controller latches req_wr, req_sel, req_addr and req_wdata. Later changes on the request inputs are ignored.
- Size N: 1, 2 or 4 bytes for req_sel 01, 10 or 11.
- Issue phase:
  - In cycles T+1 .. T+N, byte k (k = 0..N-1) drives mem_a = (addr+k) mod 2^ADDR_W.
  - Writes: mem_wr=1 and mem_dout = wdata[8k+7:8k].
  - Reads: mem_wr=0.
- Read capture: byte k is taken from mem_din in cycle T+2+k and placed in rdata[8k+7:8k]. Unfetched upper bytes are 0.
- Response timing:
  - Reads: resp_valid=1 with resp_rdata in cycle T+N+2 (DONE).
  - Writes: resp_valid=1, resp_rdata=0 in cycle T+N+1 (DONE).
- resp_valid lasts exactly one cycle.
- After DONE the controller returns to IDLE. The earliest next accept is the cycle after DONE.
- Outside ISSUE cycles: mem_wr=0, mem_a=0, mem_dout=0. The bus is never driven in IDLE, CAPTURE or DONE.
- Null request (req_sel=00): accepted, no bus activity, resp_valid at T+1 with rdata=0.
- Address wrap: byte addresses wrap modulo 2^ADDR_W, so a word at 2^ADDR_W-2 touches addresses -2, -1, 0, 1.
- Reset mid-operation: the operation aborts with no response. Bytes already written stay in RAM. mem_wr is 0 from the reset edge on.
- resp_rdata holds its last value when resp_valid=0. Only resp_valid is qualified.

Optional Feature:
- Macro: MEM_CTRL_ALIGN_CHECK_EN.
- Defined: a half at an odd address, or a word with addr[1:0]≠00, is accepted and rejected.
  - No bus activity.
  - resp_valid=1, resp_err=1, resp_rdata=0 at T+1.
  - resp_err=1 only together with resp_valid.
- Undefined: no check is made; all alignments are serialized normally; resp_err is tied to 0.

Test Plan:
- Read word: RAM[0x100..0x103] = 11 22 33 44, read word @0x00100 accepted at T -> mem_a = 0x100..0x103 in T+1..T+4, mem_wr=0, resp_valid at T+6, resp_rdata=0x44332211.
- Write half: 0x0000BEEF @0x00200 at T -> T+1: mem_a=0x200, dout=0xEF, wr=1; T+2: mem_a=0x201, dout=0xBE, wr=1; resp_valid at T+3, rdata=0. A following byte read @0x201 returns 0x000000BE.
- Wrap: read word @0x1FFFE -> mem_a sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; bytes assembled in that order.
- Reset mid-write: word write 0xAABBCCDD @0x300, rst=0 sampled at the edge ending T+2 -> RAM[0x300]=DD and RAM[0x301]=CC written, 0x302/0x303 untouched, no resp_valid, req_ready=1 and mem_wr=0 after that edge.
- Back-to-back: req_valid held high with byte read @0x10 then byte write @0x11 -> second request accepted the cycle after the first DONE; req_ready=0 throughout the busy cycles.
- Alignment (macro on): word read @0x102 -> resp_valid and resp_err at T+1, no mem_a activity. Macro off: same stimulus gives a normal 4-byte read at 0x102..0x105 with resp_err=0.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus bundle between the cache/LSU side, mem_ctrl and the byte RAM.
// Pure wiring, no latency.
// Backpressure is req_valid/req_ready; the response and RAM bus carry no backpressure.
interface mem_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_sel;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_wr;

    // Cache/LSU side: issues requests, consumes responses, and models the RAM data return.
    modport master (
        output req_valid, req_wr, req_sel, req_addr, req_wdata, mem_din,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_dout, mem_wr
    );

    // Controller side.
    modport slave (
        input  req_valid, req_wr, req_sel, req_addr, req_wdata, mem_din,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits byte/half/word requests into little-endian RAM byte cycles.
// Latency: write N+1 cycles, read N+2 cycles, null/rejected 1 cycle from accept to resp_valid.
// Backpressure: req_ready only in IDLE, one request in flight; optional MEM_CTRL_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Request latched at accept; later changes on the request inputs are ignored.
    logic              wr_q;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [1:0]        idx;       // byte index currently on the RAM bus
    logic [1:0]        last_idx;  // N-1 for the latched size
    logic [31:0]       acc;       // read bytes gathered so far
    logic [31:0]       acc_merged;
    logic [1:0]        cap_idx;
    logic              cap_en;
    logic [31:0]       rdata_q;   // holds across idle cycles, only resp_valid qualifies it
    logic [7:0]        wdata_byte;
    logic              accept;
    logic              misalign;

    logic              ready_c;
    logic              resp_vld_c;
    logic [ADDR_W-1:0] mem_a_c;
    logic [7:0]        mem_dout_c;
    logic              mem_wr_c;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic              err_q;
    assign misalign = ((bus.req_sel == 2'b10) && bus.req_addr[0]) ||
                      ((bus.req_sel == 2'b11) && (bus.req_addr[1:0] != 2'b00));
    assign bus.resp_err = (state == DONE) && err_q;
`else
    assign misalign     = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign accept = bus.req_valid && ready_c;

    // Size decode and read-byte merge: byte k arrives the cycle after its address was driven.
    always_comb begin
        last_idx = 2'd0;
        case (sel_q)
            2'b10:   last_idx = 2'd1;
            2'b11:   last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
        wdata_byte = wdata_q[{idx, 3'b000} +: 8];
        cap_en     = !wr_q && (((state == ISSUE) && (idx != 2'd0)) || (state == CAPTURE));
        cap_idx    = (state == CAPTURE) ? last_idx : (idx - 2'd1);
        acc_merged = acc;
        acc_merged[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus outputs; the RAM bus is only driven during ISSUE.
    always_comb begin
        state_nxt  = state;
        ready_c    = 1'b0;
        resp_vld_c = 1'b0;
        mem_a_c    = '0;
        mem_dout_c = 8'h00;
        mem_wr_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = ((bus.req_sel == 2'b00) || misalign) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mem_a_c    = addr_q + ADDR_W'(idx);
                mem_wr_c   = wr_q;
                mem_dout_c = wr_q ? wdata_byte : 8'h00;
                if (idx == last_idx) begin
                    state_nxt = wr_q ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = DONE;
            end
            DONE: begin
                resp_vld_c = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, byte counter, read assembly and response data register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            sel_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            idx     <= 2'd0;
            acc     <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_wr;
                sel_q   <= bus.req_sel;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                idx     <= 2'd0;
                acc     <= 32'h0;
            end else if (state == ISSUE) begin
                idx <= idx + 2'd1;
            end
            if (cap_en) begin
                acc <= acc_merged;
            end
            // Only a read leaves through CAPTURE; writes, nulls and rejects respond with zero.
            if (state_nxt == DONE) begin
                rdata_q <= (state == CAPTURE) ? acc_merged : 32'h0;
            end
        end
    end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    // Remember whether the accepted request was rejected for alignment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misalign;
        end
    end
`endif

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_vld_c;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_a      = mem_a_c;
    assign bus.mem_dout   = mem_dout_c;
    assign bus.mem_wr     = mem_wr_c;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model of 1-cycle read latency.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// Expected values are hand-computed per test scenario.
module tb_mem_ctrl;
    localparam int ADDR_W = 17;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [7:0] ram [0:(1<<ADDR_W)-1];

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, write on strobe.
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request in the current cycle T, check it is accepted, then scramble inputs in T+1.
    task automatic issue(input logic wr, input logic [1:0] sel, input logic [16:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_sel   = sel;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_wr    = ~wr;
        bus.req_sel   = 2'b11;
        bus.req_addr  = 17'h0ABCD;
        bus.req_wdata = 32'h5A5A5A5A;
    endtask

    initial begin
        logic [16:0] exp_a [4];
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_sel   = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[17'h00100] = 8'h11; ram[17'h00101] = 8'h22;
        ram[17'h00102] = 8'h33; ram[17'h00103] = 8'h44;
        ram[17'h00104] = 8'h55; ram[17'h00105] = 8'h66;
        ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2;
        ram[17'h00000] = 8'hC3; ram[17'h00001] = 8'hD4;
        ram[17'h00010] = 8'h5A;

        // Reset state.
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
        chk("rst_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_wr", 32'(bus.mem_wr), 32'd0);
        rst = 1'b1;
        tick();

        // Read word @0x100: addresses in T+1..T+4, response at T+6.
        issue(1'b0, 2'b11, 17'h00100, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("rdw_mem_a", 32'(bus.mem_a), 32'h100 + 32'(k));
            chk("rdw_wr", 32'(bus.mem_wr), 32'd0);
            chk("rdw_busy", 32'(bus.req_ready), 32'd0);
            tick();
        end
        chk("rdw_capture_idle_bus", 32'(bus.mem_a), 32'h0);
        chk("rdw_capture_no_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("rdw_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("rdw_rdata", bus.resp_rdata, 32'h44332211);
        chk("rdw_err", 32'(bus.resp_err), 32'd0);
        tick();
        chk("rdw_pulse_end", 32'(bus.resp_valid), 32'd0);
        chk("rdw_rdata_hold", bus.resp_rdata, 32'h44332211);
        chk("rdw_ready_again", 32'(bus.req_ready), 32'd1);

        // Write half 0xBEEF @0x200.
        issue(1'b1, 2'b10, 17'h00200, 32'h1234BEEF);
        chk("wrh_a0", 32'(bus.mem_a), 32'h200);
        chk("wrh_d0", 32'(bus.mem_dout), 32'hEF);
        chk("wrh_w0", 32'(bus.mem_wr), 32'd1);
        tick();
        chk("wrh_a1", 32'(bus.mem_a), 32'h201);
        chk("wrh_d1", 32'(bus.mem_dout), 32'hBE);
        chk("wrh_w1", 32'(bus.mem_wr), 32'd1);
        tick();
        chk("wrh_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("wrh_rdata", bus.resp_rdata, 32'h0);
        chk("wrh_no_wr", 32'(bus.mem_wr), 32'd0);
        chk("wrh_ram200", 32'(ram[17'h00200]), 32'hEF);
        chk("wrh_ram202", 32'(ram[17'h00202]), 32'h00);
        tick();

        // Byte read @0x201 returns the byte just written; response at T+3.
        issue(1'b0, 2'b01, 17'h00201, 32'h0);
        chk("rdb_a", 32'(bus.mem_a), 32'h201);
        tick();
        chk("rdb_capture_no_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("rdb_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("rdb_rdata", bus.resp_rdata, 32'h000000BE);
        tick();

        // Wrapped word read @0x1FFFE.
        exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
        issue(1'b0, 2'b11, 17'h1FFFE, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_mem_a", 32'(bus.mem_a), 32'(exp_a[k]));
            tick();
        end
        tick();
        chk("wrap_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("wrap_rdata", bus.resp_rdata, 32'hD4C3B2A1);
        tick();

        // Null request: no bus activity, response at T+1 with zero data.
        issue(1'b1, 2'b00, 17'h00040, 32'hFFFFFFFF);
        chk("null_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("null_rdata", bus.resp_rdata, 32'h0);
        chk("null_wr", 32'(bus.mem_wr), 32'd0);
        chk("null_mem_a", 32'(bus.mem_a), 32'h0);
        tick();

        // Reset in the middle of a word write.
        issue(1'b1, 2'b11, 17'h00300, 32'hAABBCCDD);
        chk("rstw_d0", 32'(bus.mem_dout), 32'hDD);
        tick();
        chk("rstw_d1", 32'(bus.mem_dout), 32'hCC);
        rst = 1'b0;
        tick();
        chk("rstw_wr_off", 32'(bus.mem_wr), 32'd0);
        chk("rstw_ready", 32'(bus.req_ready), 32'd1);
        chk("rstw_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("rstw_rdata_clr", bus.resp_rdata, 32'h0);
        rst = 1'b1;
        tick();
        chk("rstw_still_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("rstw_ram300", 32'(ram[17'h00300]), 32'hDD);
        chk("rstw_ram301", 32'(ram[17'h00301]), 32'hCC);
        chk("rstw_ram302", 32'(ram[17'h00302]), 32'h00);
        chk("rstw_ram303", 32'(ram[17'h00303]), 32'h00);

        // Back-to-back with req_valid held: byte read @0x10 then byte write 0x77 @0x11.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_sel   = 2'b01;
        bus.req_addr  = 17'h00010;
        chk("b2b_ready_t", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_wr    = 1'b1;
        bus.req_addr  = 17'h00011;
        bus.req_wdata = 32'h00000077;
        chk("b2b_busy1", 32'(bus.req_ready), 32'd0);
        chk("b2b_rd_a", 32'(bus.mem_a), 32'h010);
        tick();
        chk("b2b_busy2", 32'(bus.req_ready), 32'd0);
        tick();
        chk("b2b_busy3", 32'(bus.req_ready), 32'd0);
        chk("b2b_rd_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_rd_rdata", bus.resp_rdata, 32'h0000005A);
        tick();
        chk("b2b_ready_next", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_wr_a", 32'(bus.mem_a), 32'h011);
        chk("b2b_wr_d", 32'(bus.mem_dout), 32'h77);
        chk("b2b_wr_w", 32'(bus.mem_wr), 32'd1);
        tick();
        chk("b2b_wr_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_wr_rdata", bus.resp_rdata, 32'h0);
        tick();

        // Misaligned word read @0x102.
        issue(1'b0, 2'b11, 17'h00102, 32'h0);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        chk("algn_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("algn_err", 32'(bus.resp_err), 32'd1);
        chk("algn_rdata", bus.resp_rdata, 32'h0);
        chk("algn_mem_a", 32'(bus.mem_a), 32'h0);
        tick();
        chk("algn_err_drop", 32'(bus.resp_err), 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            chk("unal_mem_a", 32'(bus.mem_a), 32'h102 + 32'(k));
            chk("unal_err", 32'(bus.resp_err), 32'd0);
            tick();
        end
        tick();
        chk("unal_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("unal_rdata", bus.resp_rdata, 32'h66554433);
        chk("unal_err_done", 32'(bus.resp_err), 32'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
